// File: rtl/csr_exec_ctrl.sv
// csr_exec_ctrl: multi-cycle sequencer for Zicsr instructions plus ECALL/MRET.
// Drives an external CSR file through a combinational read port and a
// single write port, and reports completion / PC redirects to the pipeline.
// Optional feature: define CSR_ADDR_CHECK_EN to reject CSRRW/S/C accesses
// whose address lies outside the machine-mode window 12'h300-12'h3FF.
// Every output is forced to zero while rst is low, so an aborted operation
// cannot leak a write or pulse during the reset cycle itself.
module csr_exec_ctrl #(
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_src,
    input  logic [31:0] req_pc,
    output logic [11:0] csr_addr_r,
    input  logic [31:0] csr_rdata,
    output logic        csr_we,
    output logic [11:0] csr_addr_w,
    output logic [31:0] csr_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        illegal
);

    localparam logic [2:0] OP_CSRRW = 3'b001;
    localparam logic [2:0] OP_CSRRS = 3'b010;
    localparam logic [2:0] OP_CSRRC = 3'b011;
    localparam logic [2:0] OP_ECALL = 3'b100;
    localparam logic [2:0] OP_MRET  = 3'b101;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD         = 3'd1,
        WR         = 3'd2,
        TRAP_EPC   = 3'd3,
        TRAP_CAUSE = 3'd4,
        TRAP_VEC   = 3'd5,
        MRET_RD    = 3'd6,
        RESP       = 3'd7
    } state_t;

    // True for the three read-modify-write CSR instructions.
    function automatic logic f_is_csr_op(input logic [2:0] op);
        logic v;
        case (op)
            OP_CSRRW: v = 1'b1;
            OP_CSRRS: v = 1'b1;
            OP_CSRRC: v = 1'b1;
            default:  v = 1'b0;
        endcase
        return v;
    endfunction

    // New CSR value for a read-modify-write instruction.
    function automatic logic [31:0] f_csr_wdata(input logic [2:0]  op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] src);
        logic [31:0] v;
        case (op)
            OP_CSRRW: v = src;
            OP_CSRRS: v = old_val | src;
            OP_CSRRC: v = old_val & ~src;
            default:  v = 32'd0;
        endcase
        return v;
    endfunction

    // Set/clear with a zero mask must not write (avoids side effects on
    // CSRs whose writes have consequences); CSRRW always writes.
    function automatic logic f_csr_we(input logic [2:0] op, input logic [31:0] src);
        logic v;
        case (op)
            OP_CSRRW: v = 1'b1;
            OP_CSRRS: v = (src != 32'd0);
            OP_CSRRC: v = (src != 32'd0);
            default:  v = 1'b0;
        endcase
        return v;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [11:0] r_addr;
    logic [31:0] r_src;
    logic [31:0] r_pc;
    logic [31:0] r_old;
    logic        r_illegal;

    logic        w_accept;
    logic        w_req_illegal;
    logic        w_op_known;

    logic [11:0] w_csr_addr_r;
    logic        w_csr_we;
    logic [11:0] w_csr_addr_w;
    logic [31:0] w_csr_wdata;
    logic        w_resp_valid;
    logic [31:0] w_resp_rdata;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_illegal;

    assign req_ready = rst & (r_state == IDLE);
    assign w_accept  = req_valid & req_ready;

    // Classify the incoming request as legal or illegal at accept time.
    always_comb begin
        w_op_known    = f_is_csr_op(req_op) | (req_op == OP_ECALL) | (req_op == OP_MRET);
        w_req_illegal = ~w_op_known;
`ifdef CSR_ADDR_CHECK_EN
        if (f_is_csr_op(req_op) && (req_addr[11:8] != 4'h3)) begin
            w_req_illegal = 1'b1;
        end else begin
            w_req_illegal = ~w_op_known;
        end
`else
        if (f_is_csr_op(req_op)) begin
            w_req_illegal = 1'b0;
        end else begin
            w_req_illegal = ~w_op_known;
        end
`endif
    end

    // Next-state logic for the sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_illegal) begin
                        w_next = RESP;
                    end else begin
                        case (req_op)
                            OP_CSRRW: w_next = RD;
                            OP_CSRRS: w_next = RD;
                            OP_CSRRC: w_next = RD;
                            OP_ECALL: w_next = TRAP_EPC;
                            OP_MRET:  w_next = MRET_RD;
                            default:  w_next = RESP;
                        endcase
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            RD:         w_next = WR;
            WR:         w_next = RESP;
            TRAP_EPC:   w_next = TRAP_CAUSE;
            TRAP_CAUSE: w_next = TRAP_VEC;
            TRAP_VEC:   w_next = RESP;
            MRET_RD:    w_next = RESP;
            RESP:       w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // State register, request latch and old-value capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_op      <= 3'd0;
            r_addr    <= 12'd0;
            r_src     <= 32'd0;
            r_pc      <= 32'd0;
            r_old     <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op      <= req_op;
                r_addr    <= req_addr;
                r_src     <= req_src;
                r_pc      <= req_pc;
                r_old     <= 32'd0;
                r_illegal <= w_req_illegal;
            end else if (r_state == RD) begin
                r_old <= csr_rdata;
            end
        end
    end

    // Per-state decode of the CSR-file, response and redirect outputs.
    always_comb begin
        w_csr_addr_r     = 12'd0;
        w_csr_we         = 1'b0;
        w_csr_addr_w     = 12'd0;
        w_csr_wdata      = 32'd0;
        w_resp_valid     = 1'b0;
        w_resp_rdata     = 32'd0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'd0;
        w_illegal        = 1'b0;
        case (r_state)
            RD: begin
                w_csr_addr_r = r_addr;
            end
            WR: begin
                w_csr_addr_w = r_addr;
                w_csr_we     = f_csr_we(r_op, r_src);
                w_csr_wdata  = f_csr_wdata(r_op, r_old, r_src);
            end
            TRAP_EPC: begin
                w_csr_we     = 1'b1;
                w_csr_addr_w = MEPC_ADDR;
                w_csr_wdata  = r_pc;
            end
            TRAP_CAUSE: begin
                w_csr_we     = 1'b1;
                w_csr_addr_w = MCAUSE_ADDR;
                w_csr_wdata  = ECALL_CAUSE;
            end
            TRAP_VEC: begin
                // mtvec low bits are the mode field; only direct mode is used.
                w_csr_addr_r     = MTVEC_ADDR;
                w_redirect_valid = 1'b1;
                w_redirect_pc    = csr_rdata & ~32'h3;
            end
            MRET_RD: begin
                w_csr_addr_r     = MEPC_ADDR;
                w_redirect_valid = 1'b1;
                w_redirect_pc    = csr_rdata;
            end
            RESP: begin
                w_resp_valid = 1'b1;
                w_illegal    = r_illegal;
                if (f_is_csr_op(r_op) && !r_illegal) begin
                    w_resp_rdata = r_old;
                end else begin
                    w_resp_rdata = 32'd0;
                end
            end
            default: begin
                w_csr_addr_r = 12'd0;
            end
        endcase
    end

    assign csr_addr_r     = rst ? w_csr_addr_r  : 12'd0;
    assign csr_we         = rst & w_csr_we;
    assign csr_addr_w     = rst ? w_csr_addr_w  : 12'd0;
    assign csr_wdata      = rst ? w_csr_wdata   : 32'd0;
    assign resp_valid     = rst & w_resp_valid;
    assign resp_rdata     = rst ? w_resp_rdata  : 32'd0;
    assign redirect_valid = rst & w_redirect_valid;
    assign redirect_pc    = rst ? w_redirect_pc : 32'd0;
    assign illegal        = rst & w_illegal;

endmodule
